sram_access_arbiter: RTL
========================

Name: sram_access_arbiter

Overview:
- Shares the single external SRAM port between the UART-fed frame writer and the video playback reader.
- Sequences every access as a fixed setup/strobe/release cycle and drives the shared SRAM control, address and data lines.
- Returns a one-cycle completion pulse to the requester it served.
- Sits between the loader/player units and the SRAM pad logic.

Parameters:
- ADDR_W, 19, SRAM word address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, strobe-active cycles per access. Legal range 1..15; 0 behaves as 1.

Ports:
- clk  in  1  system clock, same clock as UART and write units.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  writer request level; held until wr_done.
- wr_addr  in  ADDR_W  write address, sampled at grant.
- wr_data  in  DATA_W  write data, sampled at grant.
- wr_done  out  1  one-cycle pulse: write completed.
- rd_req  in  1  reader request level; held until rd_valid.
- rd_addr  in  ADDR_W  read address, sampled at grant.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  one-cycle pulse: rd_data updated.
- sram_selec  out  1  chip select.
- sram_write  out  1  write strobe.
- sram_read  out  1  read strobe.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  data to SRAM.
- sram_din  in  DATA_W  data from SRAM.
- sram_oe  out  1  pad drive enable for sram_dout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async assert, any state): all outputs 0; state IDLE; strobe counter 0; last-grant flag = writer.
- States and transitions:
  - IDLE: arbitrate. If any request is present, latch address/data and the operation type, then go to SETUP. Otherwise stay in IDLE.
  - SETUP, 1 cycle: sram_addr valid, sram_selec=1, strobes 0. For writes, sram_oe=1 and sram_dout valid. Then go to ACCESS.
  - ACCESS, WAIT_CYCLES cycles: sram_selec=1, and sram_write or sram_read=1 according to the operation. On the last ACCESS cycle of a read, capture sram_din into rd_data. Then go to RELEASE.
  - RELEASE, 1 cycle: sram_selec and both strobes 0. Address and data stay held; sram_oe stays 1 for writes (hold time). Pulse wr_done or rd_valid. Then go to IDLE.
- Latency: grant (IDLE sample) to done pulse = WAIT_CYCLES + 2 cycles. The next grant occurs at the earliest on the cycle after the return to IDLE.
- sram_write and sram_read are never high together; both are 0 whenever sram_selec=0.
- Handshake:
  - A requester must drop its request in the cycle after its done pulse. A request still high in IDLE is treated as a new request.
  - A request that drops mid-transaction does not abort it; the access completes and the done pulse is still issued.
  - Address and data changes after grant are ignored.
- Arbitration (default): fixed priority, reader wins when both requests are present in IDLE, so playback is never starved.
- Reset mid-transaction: strobes drop immediately and no done pulse is issued. The requester re-requests after reset.
- rd_data holds its last value until the next read completes.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are present, grant the requester that was not granted last. The last-grant flag updates at each grant.
- Undefined: fixed reader priority as above; the last-grant flag is unused and optimized away.

Test Plan:
- Single write:
  - Stimulus: wr_req with addr 0x00005, data 0xA55A, WAIT_CYCLES=2.
  - Response: SETUP 1 cycle, sram_write high for 2 cycles with sram_addr=0x00005 and sram_dout=0xA55A; wr_done pulses exactly 4 cycles after grant.
- Single read:
  - Stimulus: rd_req with addr 0x7FFFF, sram_din=0x1234 during ACCESS.
  - Response: rd_valid pulses 1 cycle with rd_data=0x1234; sram_oe stays 0 throughout.
- Simultaneous requests, macro off:
  - Stimulus: wr_req and rd_req raised in the same cycle, three times.
  - Response: reader served first each time; writer served after each read.
- Simultaneous requests, macro SRAM_ARB_RR_EN on:
  - Stimulus: both requests held continuously.
  - Response: grants alternate R, W, R, W, starting with the reader (reset last-grant = writer).
- Reset mid-access:
  - Stimulus: assert rst during the 2nd ACCESS cycle of a write.
  - Response: sram_write, sram_selec and busy go 0 asynchronously; no wr_done; after release, a fresh wr_req completes normally.
- Request dropped mid-transaction:
  - Stimulus: deassert rd_req during SETUP.
  - Response: access still completes and rd_valid still pulses once; IDLE follows with no regrant.

Source files
------------

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM port between the frame writer and the playback reader.
// Each access runs setup/strobe/release; define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_access_arbiter #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              sram_selec,
    output logic              sram_write,
    output logic              sram_read,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_oe,
    output logic              busy
);

    // state   | meaning
    // IDLE    | arbitrate, latch the winning request
    // SETUP   | address/select (and write data) valid, strobes low
    // ACCESS  | strobe active for WAIT_CYCLES cycles
    // RELEASE | select/strobes low, address/data held, done pulse
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

    localparam int         EFF_WAIT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] CNT_LOAD = 4'(EFF_WAIT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       op_rd;
    logic       grant_rd;

`ifdef SRAM_ARB_RR_EN
    logic last_wr;

    // On contention, serve whoever was not granted last.
    always_comb grant_rd = rd_req && (!wr_req || last_wr);
`else
    always_comb grant_rd = rd_req;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_rd      <= 1'b0;
            wr_done    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            sram_selec <= 1'b0;
            sram_write <= 1'b0;
            sram_read  <= 1'b0;
            sram_addr  <= '0;
            sram_dout  <= '0;
            sram_oe    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_wr    <= 1'b1;
`endif
        end else begin
            wr_done  <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        op_rd      <= grant_rd;
                        sram_addr  <= grant_rd ? rd_addr : wr_addr;
                        sram_oe    <= !grant_rd;
                        sram_selec <= 1'b1;
                        if (!grant_rd)
                            sram_dout <= wr_data;
`ifdef SRAM_ARB_RR_EN
                        last_wr    <= !grant_rd;
`endif
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    sram_write <= !op_rd;
                    sram_read  <= op_rd;
                    cnt        <= CNT_LOAD;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        sram_selec <= 1'b0;
                        sram_write <= 1'b0;
                        sram_read  <= 1'b0;
                        if (op_rd) begin
                            rd_data  <= sram_din;
                            rd_valid <= 1'b1;
                        end else begin
                            wr_done  <= 1'b1;
                        end
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RELEASE: begin
                    // Write data stayed driven through this cycle for hold time.
                    sram_oe <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
